pc_module: RTL and testbench
============================

PC_MODULE -- requirements
Module: pc_module

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 16'd0, meaning the PC value loaded on reset.
REQ-002 The block SHALL have parameter PC_DEFAULT, default 4'd0, meaning the sequential-increment select code.
REQ-003 The block SHALL have parameter PC_IMM, default 4'd1, meaning the J-type PC-relative jump select code.
REQ-004 The block SHALL have parameter PC_SGN_IMM, default 4'd2, meaning the I-type PC-relative taken-branch select code.
REQ-005 The block SHALL have parameter PC_RET, default 4'd3, meaning the return-via-R7 select code.
REQ-006 The block SHALL have port clock, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port PC, output, 16 bits: the current program counter, driven directly from a register.
REQ-009 The block SHALL have port I_TypeImmediate, input, 16 bits: signed, already-extended branch offset.
REQ-010 The block SHALL have port J_TypeImmediate, input, 16 bits: signed, already-extended jump offset.
REQ-011 The block SHALL have port R7, input, 16 bits: return-address register value.
REQ-012 The block SHALL have port sig_pc_src, input, 4 bits: next-PC source select.

Function
REQ-013 PC SHALL be a 16-bit register updated only on the rising edge of clock.
REQ-014 Next PC SHALL be selected combinationally from the current PC and the current inputs, giving a latency of exactly one edge from input to PC.
REQ-015 sig_pc_src==PC_DEFAULT SHALL give next PC = PC + 1 (word-addressed).
REQ-016 sig_pc_src==PC_IMM SHALL give next PC = PC + J_TypeImmediate, computed in two's complement; negative offsets move PC backwards.
REQ-017 sig_pc_src==PC_SGN_IMM SHALL give next PC = PC + I_TypeImmediate, computed in two's complement.
REQ-018 sig_pc_src==PC_RET SHALL give next PC = R7 (absolute).
REQ-019 Any other sig_pc_src value SHALL behave as PC_DEFAULT.
REQ-020 All additions SHALL be 16-bit modulo 2^16 with no overflow flag, so that 16'hFFFF + 1 gives 16'h0000 and 16'h0002 + (-10) gives 16'hFFF8.
REQ-021 Immediates and R7 SHALL be sampled only at the same edge that updates PC; changes between edges SHALL have no effect on PC.
REQ-022 X/Z on an unselected data input SHALL NOT affect PC.

Reset
REQ-023 When reset==1 at a rising edge, PC SHALL become RESET_PC (0), overriding every sig_pc_src value.
REQ-024 Reset asserted mid-sequence SHALL take effect at the next edge, and the first edge after deassertion SHALL apply the normal selection to PC=RESET_PC.
REQ-025 Before the first reset edge, PC SHALL NOT be relied on (simulation may show X).
REQ-026 The bench SHALL use a free-running 10 ns period clock and SHALL apply reset for at least 1 cycle.

Verification
REQ-027 Reset, then one edge with PC_DEFAULT -> PC goes 0 -> 1.
REQ-028 PC_RET with R7=2 -> PC=2; then PC_IMM with J=+10 -> PC=12; then PC_IMM with J=-10 -> PC=2; then PC_SGN_IMM with I=+8 -> PC=10.
REQ-029 PC=16'hFFFF with PC_DEFAULT -> PC=16'h0000; PC=2 with PC_IMM and J=-10 -> PC=16'hFFF8.
REQ-030 sig_pc_src=4'hF from PC=5 -> PC=6.
REQ-031 Reset asserted with PC_RET and R7=100 -> PC=0; after deassertion with PC_DEFAULT -> PC=1.
REQ-032 PC_DEFAULT with I, J and R7 driven X -> PC increments normally.

Source files
------------

// File: rtl/pc_module_if.sv
// Program-counter bundle: next-PC sources from the decoder and the PC itself.
// The master side selects the next PC; the slave side holds the PC register.
interface pc_module_if;
  logic [15:0] PC;
  logic [15:0] I_TypeImmediate;
  logic [15:0] J_TypeImmediate;
  logic [15:0] R7;
  logic [3:0]  sig_pc_src;

  modport master (
    output I_TypeImmediate,
    output J_TypeImmediate,
    output R7,
    output sig_pc_src,
    input  PC
  );

  modport slave (
    input  I_TypeImmediate,
    input  J_TypeImmediate,
    input  R7,
    input  sig_pc_src,
    output PC
  );
endinterface

// File: rtl/pc_module.sv
// Program counter: one register and a next-PC mux over increment,
// PC-relative jump/branch and absolute return through R7.
module pc_module #(
  parameter logic [15:0] RESET_PC   = 16'd0,
  parameter logic [3:0]  PC_DEFAULT = 4'd0,
  parameter logic [3:0]  PC_IMM     = 4'd1,
  parameter logic [3:0]  PC_SGN_IMM = 4'd2,
  parameter logic [3:0]  PC_RET     = 4'd3
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] PC,
  input  logic [15:0] I_TypeImmediate,
  input  logic [15:0] J_TypeImmediate,
  input  logic [15:0] R7,
  input  logic [3:0]  sig_pc_src
);

  logic [15:0] pc_q;
  logic [15:0] pc_d;
  logic [15:0] pc_inc;
  logic [15:0] pc_jmp;
  logic [15:0] pc_br;

  logic sel_imm;
  logic sel_sgn;
  logic sel_ret;

  // Modulo-2^16 adds; offsets arrive sign-extended so plain add wraps right.
  assign pc_inc = pc_q + 16'd1;
  assign pc_jmp = pc_q + J_TypeImmediate;
  assign pc_br  = pc_q + I_TypeImmediate;

  assign sel_imm = (sig_pc_src == PC_IMM);
  assign sel_sgn = (sig_pc_src == PC_SGN_IMM);
  assign sel_ret = (sig_pc_src == PC_RET);

  always_comb begin
    pc_d = pc_inc;
    unique case (1'b1)
      sel_imm: pc_d = pc_jmp;
      sel_sgn: pc_d = pc_br;
      sel_ret: pc_d = R7;
      default: pc_d = pc_inc;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign PC = pc_q;

endmodule

// File: tb/tb_pc_module.sv
// Directed bench for pc_module: hand-computed PC after each edge.
// Inputs are driven 1 ns after the edge, PC is sampled at the same point.
module tb_pc_module;

  localparam logic [3:0] P_DEF = 4'd0;
  localparam logic [3:0] P_IMM = 4'd1;
  localparam logic [3:0] P_SGN = 4'd2;
  localparam logic [3:0] P_RET = 4'd3;

  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  pc_module_if bus ();

  pc_module dut (
    .clock           (clock),
    .reset           (reset),
    .PC              (bus.PC),
    .I_TypeImmediate (bus.I_TypeImmediate),
    .J_TypeImmediate (bus.J_TypeImmediate),
    .R7              (bus.R7),
    .sig_pc_src      (bus.sig_pc_src)
  );

  always #5 clock = ~clock;

  task automatic drive(input logic [3:0] src,
                       input logic [15:0] i_imm,
                       input logic [15:0] j_imm,
                       input logic [15:0] r7);
    bus.sig_pc_src      = src;
    bus.I_TypeImmediate = i_imm;
    bus.J_TypeImmediate = j_imm;
    bus.R7              = r7;
  endtask

  task automatic check(input string tag, input logic [15:0] exp);
    total++;
    assert (bus.PC === exp) else begin
      bad++;
      $error("FAIL %s: PC=%h expected %h", tag, bus.PC, exp);
    end
  endtask

  task automatic step(input string tag, input logic [15:0] exp);
    @(posedge clock);
    #1;
    check(tag, exp);
  endtask

  initial begin
    reset = 1'b1;
    drive(P_RET, 16'd0, 16'd0, 16'd100);
    step("reset0", 16'h0000);
    step("reset1", 16'h0000);

    reset = 1'b0;
    drive(P_DEF, 16'd0, 16'd0, 16'd0);
    step("inc0to1", 16'h0001);

    drive(P_RET, 16'd0, 16'd0, 16'd2);
    step("ret2", 16'h0002);
    drive(P_IMM, 16'd0, 16'd10, 16'd0);
    step("jmp+10", 16'h000C);
    drive(P_IMM, 16'd0, 16'hFFF6, 16'd0);
    step("jmp-10", 16'h0002);
    drive(P_SGN, 16'd8, 16'd0, 16'd0);
    step("br+8", 16'h000A);

    drive(P_RET, 16'd0, 16'd0, 16'hFFFF);
    step("retFFFF", 16'hFFFF);
    drive(P_DEF, 16'd0, 16'd0, 16'd0);
    step("incwrap", 16'h0000);
    drive(P_SGN, 16'hFFFE, 16'd0, 16'd0);
    step("br-2wrap", 16'hFFFE);

    drive(P_RET, 16'd0, 16'd0, 16'd2);
    step("ret2b", 16'h0002);
    drive(P_IMM, 16'd0, 16'hFFF6, 16'd0);
    step("jmpneg", 16'hFFF8);

    drive(P_RET, 16'd0, 16'd0, 16'd5);
    step("ret5", 16'h0005);
    drive(4'hF, 16'd0, 16'd0, 16'd0);
    step("srcF", 16'h0006);
    drive(4'h4, 16'd7, 16'd7, 16'd7);
    step("src4", 16'h0007);

    drive(P_DEF, 16'hxxxx, 16'hxxxx, 16'hxxxx);
    step("incX", 16'h0008);

    drive(P_RET, 16'd0, 16'd0, 16'd77);
    #2;
    check("noedge", 16'h0008);
    bus.R7 = 16'd300;
    #1;
    bus.R7 = 16'd77;
    step("ret77", 16'd77);

    reset = 1'b1;
    drive(P_RET, 16'd0, 16'd0, 16'd100);
    step("midreset", 16'h0000);
    reset = 1'b0;
    drive(P_DEF, 16'd0, 16'd0, 16'd0);
    step("postreset", 16'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
